// File: rtl/comparator_share_arbiter.sv
// comparator_share_arbiter
//   Sequencer/arbiter in front of one shared combinational 6-bit set-membership
//   comparator. Up to NREQ requesters are served round-robin; each accepted
//   code is driven to the comparator and the member flag is returned with the
//   owner's index over a valid/ready handshake. A self-test scan sweeps codes
//   0..63 through the comparator and reports how many are members.
//
// Ports
//   Reloj        clock, rising edge
//   Reset        synchronous active-high reset
//   Req          per-requester request level, held until Ack
//   ReqCodigo    6-bit code per requester, slice i = [6i+5:6i]
//   Ack          grant pulse (combinational, IDLE only); code captured on that edge
//   CompEntrada  registered code driven to the comparator
//   CompSalida   comparator member flag for CompEntrada
//   RespValid    result available; RespMatch/RespId stable while high
//   RespReady    consumer accepts result
//   RespMatch    1 = code is a set member
//   RespId       requester index owning the result
//   ScanStart    pulse requesting a full scan
//   ScanBusy     high while the scan runs
//   ScanDone     one-cycle pulse at scan end
//   ScanCount    member count of the last completed scan
module comparator_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic              Reloj,
  input  logic              Reset,
  input  logic [NREQ-1:0]   Req,
  input  logic [6*NREQ-1:0] ReqCodigo,
  output logic [NREQ-1:0]   Ack,
  output logic [5:0]        CompEntrada,
  input  logic              CompSalida,
  output logic              RespValid,
  input  logic              RespReady,
  output logic              RespMatch,
  output logic [IDW-1:0]    RespId,
  input  logic              ScanStart,
  output logic              ScanBusy,
  output logic              ScanDone,
  output logic [6:0]        ScanCount
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;
  localparam logic [1:0] S_SCAN    = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic           pend_q, pend_d;
  logic [5:0]     comp_q, comp_d;
  logic           valid_q, valid_d;
  logic           match_q, match_d;
  logic [IDW-1:0] id_q, id_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [6:0]     count_q, count_d;
  logic [6:0]     cnt_q, cnt_d;

  logic           gnt_found_s;
  logic [IDW-1:0] gnt_idx_s;
  logic [5:0]     gnt_code_s;
  logic           grant_s;

  // Round-robin pick: lowest requester at/above the pointer, else lowest overall.
  always_comb begin
    logic           found_hi;
    logic           found_lo;
    logic [IDW-1:0] idx_hi;
    logic [IDW-1:0] idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (Req[i]) begin
        if (!found_hi && (i >= int'(rr_q))) begin
          found_hi = 1'b1;
          idx_hi   = IDW'(i);
        end else begin
          found_hi = found_hi;
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          idx_lo   = IDW'(i);
        end else begin
          found_lo = found_lo;
        end
      end else begin
        found_lo = found_lo;
      end
    end
    gnt_found_s = found_lo;
    gnt_idx_s   = found_hi ? idx_hi : idx_lo;
  end

  // Grant decode: Ack only in IDLE with no scan pending; Reset masks it.
  always_comb begin
    grant_s    = (state_q == S_IDLE) && !pend_q && gnt_found_s && !Reset;
    gnt_code_s = 6'd0;
    Ack        = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx_s) begin
        gnt_code_s = ReqCodigo[6*i +: 6];
        Ack[i]     = grant_s;
      end else begin
        Ack[i] = 1'b0;
      end
    end
  end

  // Next-state logic for the sequencer FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    pend_d  = pend_q;
    comp_d  = comp_q;
    valid_d = valid_q;
    match_d = match_q;
    id_d    = id_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;
    cnt_d   = cnt_q;

    // A scan request is remembered everywhere except during the scan itself.
    if (ScanStart && (state_q != S_SCAN)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_SCAN;
          pend_d  = 1'b0;
          comp_d  = 6'd0;
          cnt_d   = 7'd0;
          busy_d  = 1'b1;
        end else if (gnt_found_s) begin
          state_d = S_COMPARE;
          comp_d  = gnt_code_s;
          id_d    = gnt_idx_s;
          rr_d    = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPARE: begin
        match_d = CompSalida;
        valid_d = 1'b1;
        state_d = S_RESPOND;
      end
      S_RESPOND: begin
        if (RespReady) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESPOND;
        end
      end
      S_SCAN: begin
        cnt_d  = cnt_q + {6'd0, CompSalida};
        comp_d = comp_q + 6'd1;
        // Code 63 is the last one; its flag is folded into the reported total.
        if (comp_q == 6'd63) begin
          count_d = cnt_q + {6'd0, CompSalida};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          comp_d  = 6'd0;
          state_d = S_IDLE;
        end else begin
          state_d = S_SCAN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      pend_q  <= 1'b0;
      comp_q  <= 6'd0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 7'd0;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      comp_q  <= comp_d;
      valid_q <= valid_d;
      match_q <= match_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CompEntrada = comp_q;
  assign RespValid   = valid_q;
  assign RespMatch   = match_q;
  assign RespId      = id_q;
  assign ScanBusy    = busy_q;
  assign ScanDone    = done_q;
  assign ScanCount   = count_q;

endmodule

// File: doc/comparator_share_arbiter.md
Name: comparator_share_arbiter

Overview:
- Sequencer and arbiter for the shared 22-member 6-bit set comparator (one combinational instance: 6-bit code in, 1-bit member flag out).
- Grants up to NREQ requesters round-robin access to the comparator and returns a registered match result with requester ID over a valid/ready handshake.
- Also provides a self-test scan mode: sweeps codes 0..63 through the comparator, counts members and reports the total.

Parameters:
- NREQ, 2, number of requesters (1..4).
- IDW, 2, width of RespId (must satisfy 2**IDW >= NREQ).

Ports:
- Reloj  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  NREQ  per-requester request level; hold until Ack.
- ReqCodigo  in  6*NREQ  6-bit code per requester; slice i = [6i+5:6i].
- Ack  out  NREQ  one-cycle pulse; request i accepted and its code captured.
- CompEntrada  out  6  code driven to the comparator; registered.
- CompSalida  in  1  comparator output; combinational from CompEntrada.
- RespValid  out  1  result available.
- RespReady  in  1  consumer accepts result.
- RespMatch  out  1  1 = code is a set member.
- RespId  out  IDW  index of the requester owning the result.
- ScanStart  in  1  one-cycle pulse requesting a full 0..63 scan.
- ScanBusy  out  1  high while the scan runs.
- ScanDone  out  1  one-cycle pulse at scan end.
- ScanCount  out  7  members counted in the last scan (0..64).

Behaviour:
- Reset values: Ack=0, CompEntrada=0, RespValid=0, RespMatch=0, RespId=0, ScanBusy=0, ScanDone=0, ScanCount=0. RR pointer=0, scan pending=0, state=IDLE.
- Reset mid-operation aborts any transaction or scan with no response and no ScanDone. Reset dominates all inputs.
- FSM states: IDLE, COMPARE, RESPOND, SCAN.
- IDLE:
  - If scan pending: go to SCAN, CompEntrada<=0, counter<=0, ScanBusy<=1.
  - Else if any Req: grant the first requester at or after the RR pointer (cyclic). Pulse Ack[g], CompEntrada<=code g, RespId<=g, pointer<=(g+1) mod NREQ, go to COMPARE.
  - Else stay in IDLE.
- COMPARE: one cycle. RespMatch<=CompSalida, RespValid<=1, go to RESPOND.
- RESPOND:
  - RespValid, RespMatch and RespId are held stable until RespReady=1.
  - On the RespReady cycle: RespValid<=0, go to IDLE.
  - No new grant in the same cycle; minimum request-to-request spacing is 3 cycles.
- Latency: Ack edge to RespValid edge is 2 cycles when RespReady is held high.
- SCAN:
  - Each cycle add CompSalida to a 7-bit counter and increment CompEntrada.
  - When CompEntrada=63 is sampled: ScanCount<=final sum, ScanDone pulses 1 cycle, ScanBusy<=0, CompEntrada<=0, go to IDLE.
  - A scan takes exactly 64 cycles in SCAN. The counter cannot overflow (max 64).
  - CompEntrada wraps 63 to 0 only at scan exit.
- ScanStart handling:
  - Sets the scan-pending flag in any state. Pending is cleared on SCAN entry.
  - ScanStart during SCAN is ignored; the flag is not set.
  - Pending scan has priority over Req in IDLE. An in-flight transaction always completes before the scan.
- Requests are stalled (no Ack) during COMPARE, RESPOND and SCAN. Req/ReqCodigo are sampled only in IDLE.
- Simultaneous ScanStart and Req in IDLE with no pending scan: the Req wins this cycle; the scan starts on the next return to IDLE.
- ScanCount holds its value until the next scan completes or Reset.

Test Plan:
- Bench comparator model members = {1,2,3,5,10,12,13,15,20,21,22,23,25,30,31,32,33,35,50,51,52,53}.
- Single request: Req=01, code 12, RespReady=1 -> Ack[0] in cycle 0; RespValid=1, RespMatch=1, RespId=0 at cycle 2; code 4 -> RespMatch=0.
- Contention: Req=11 held, codes 1 (req0) and 40 (req1) -> grants alternate 0,1,0,1; responses (Id0,match1),(Id1,match0) repeat; no starvation over 8 grants.
- Backpressure: RespReady=0 for 5 cycles after RespValid -> RespValid/RespMatch/RespId stable, no Ack while stalled; RespReady=1 -> next Ack 1 cycle later.
- Scan: ScanStart pulse in IDLE -> ScanBusy high 64 cycles, CompEntrada 0..63 in order, ScanDone pulse, ScanCount=22; a Req asserted during the scan gets Ack only after ScanDone.
- ScanStart during RESPOND with Req pending -> the response completes, scan runs before the Req is granted, ScanCount=22.
- Reset asserted at scan cycle 30 -> all outputs at reset values next cycle, no ScanDone, ScanCount=0.
